// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard unit for a pipelined core with variable-latency writers (loads,
//   mul/div). Tracks which registers have a long-latency write in flight,
//   counts outstanding long ops, and watches for decode stalls that never end.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   issue_d, issue_long_d       decode holds a valid (long-latency) instruction
//   rd_d, rs1_d, rs2_d          decode destination / source registers
//   use_rs1_d, use_rs2_d        decode sources actually read
//   wb_valid, wb_rd             long-op completion port
//   stage_wr, stage_rd          per-stage write enable / rd of the bypass stages
//   rs1_e, rs2_e                execute source registers
//   redirect_e                  taken branch / jump resolved in execute
//   fwd_rs1_e, fwd_rs2_e        one-hot bypass select (bit0 regfile, bit k+1 stage k)
//   stall_f, stall_d            hold PC / decode register
//   flush_d, flush_e            kill decode / bubble into execute
//   outstanding, busy           in-flight long-op count and its nonzero flag
//   err_spurious, hang          sticky error flags
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREGS       = 32,
    parameter int RW          = 5,
    parameter int NSTAGES     = 2,
    parameter int MAX_OUT     = 4,
    parameter int STALL_LIMIT = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           issue_d,
    input  logic                           issue_long_d,
    input  logic [RW-1:0]                  rd_d,
    input  logic [RW-1:0]                  rs1_d,
    input  logic [RW-1:0]                  rs2_d,
    input  logic                           use_rs1_d,
    input  logic                           use_rs2_d,
    input  logic                           wb_valid,
    input  logic [RW-1:0]                  wb_rd,
    input  logic [NSTAGES-1:0]             stage_wr,
    input  logic [NSTAGES*RW-1:0]          stage_rd,
    input  logic [RW-1:0]                  rs1_e,
    input  logic [RW-1:0]                  rs2_e,
    input  logic                           redirect_e,
    output logic [NSTAGES:0]               fwd_rs1_e,
    output logic [NSTAGES:0]               fwd_rs2_e,
    output logic                           stall_f,
    output logic                           stall_d,
    output logic                           flush_d,
    output logic                           flush_e,
    output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
    output logic                           busy,
    output logic                           err_spurious,
    output logic                           hang
);

    localparam int OW   = $clog2(MAX_OUT + 1);
    localparam int SW   = $clog2(STALL_LIMIT + 1);
    localparam int NIDX = 2 ** RW;
    localparam logic [OW-1:0] MAX_OUT_C     = OW'(MAX_OUT);
    localparam logic [SW-1:0] STALL_LIMIT_C = SW'(STALL_LIMIT);

    logic [NREGS-1:0] pending_reg, pending_next;
    logic [OW-1:0]    outstanding_reg, outstanding_next;
    logic [SW-1:0]    stall_cnt_reg, stall_cnt_next;
    logic             err_reg, hang_reg;

    // Pending view widened to the full index space so any RW-bit index is
    // legal; registers beyond NREGS read as never pending.
    logic [NIDX-1:0]  pend_view;

    logic raw_haz, waw_haz, full_haz, stall_c, accept_c, complete_c, spurious_c;

    genvar gi;
    generate
        for (gi = 0; gi < NIDX; gi++) begin : g_view
            if (gi < NREGS) begin : g_real
                assign pend_view[gi] = pending_reg[gi];
            end else begin : g_pad
                assign pend_view[gi] = 1'b0;
            end
        end
    endgenerate

    assign raw_haz  = issue_d & ((use_rs1_d & pend_view[rs1_d]) | (use_rs2_d & pend_view[rs2_d]));
    assign waw_haz  = issue_d & issue_long_d & pend_view[rd_d];
    assign full_haz = issue_d & issue_long_d & (outstanding_reg == MAX_OUT_C);

    // A redirect kills the instruction in decode, so it never needs to wait.
    assign stall_c    = (raw_haz | waw_haz | full_haz) & ~redirect_e;
    assign accept_c   = issue_d & issue_long_d & (rd_d != '0) & ~stall_c & ~redirect_e;
    assign complete_c = wb_valid & pend_view[wb_rd];
    assign spurious_c = wb_valid & ~pend_view[wb_rd];

    // Per-register next state; x0 is hardwired to never pending. When the
    // same register is issued and completed together, the new issue wins.
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_pend
            if (gi == 0) begin : g_x0
                assign pending_next[gi] = 1'b0;
            end else begin : g_xn
                assign pending_next[gi] = (accept_c & (rd_d == RW'(gi))) |
                                          (pending_reg[gi] & ~(complete_c & (wb_rd == RW'(gi))));
            end
        end
    endgenerate

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({accept_c, complete_c})
            2'b10:   outstanding_next = outstanding_reg + 1'b1;
            2'b01:   outstanding_next = outstanding_reg - 1'b1;
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_comb begin
        stall_cnt_next = '0;
        if (stall_c) begin
            stall_cnt_next = (stall_cnt_reg == STALL_LIMIT_C) ? stall_cnt_reg
                                                              : stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg     <= '0;
            outstanding_reg <= '0;
            stall_cnt_reg   <= '0;
            err_reg         <= 1'b0;
            hang_reg        <= 1'b0;
        end else begin
            pending_reg     <= pending_next;
            outstanding_reg <= outstanding_next;
            stall_cnt_reg   <= stall_cnt_next;
            err_reg         <= err_reg | spurious_c;
            hang_reg        <= hang_reg | (stall_cnt_next == STALL_LIMIT_C);
        end
    end

    // Lowest-indexed (youngest) stage wins: scan from oldest to youngest so
    // the last hit assigned is the youngest.
    function automatic logic [NSTAGES:0] fwd_sel(input logic [RW-1:0] rs);
        logic [NSTAGES:0] sel;
        sel    = '0;
        sel[0] = 1'b1;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if ((rs != '0) && stage_wr[k] && (stage_rd[k*RW +: RW] == rs)) begin
                sel        = '0;
                sel[k + 1] = 1'b1;
            end
        end
        return sel;
    endfunction

    assign fwd_rs1_e    = fwd_sel(rs1_e);
    assign fwd_rs2_e    = fwd_sel(rs2_e);
    assign stall_d      = stall_c;
    assign stall_f      = stall_c;
    assign flush_d      = redirect_e;
    assign flush_e      = stall_c | redirect_e;
    assign outstanding  = outstanding_reg;
    assign busy         = (outstanding_reg != '0);
    assign err_spurious = err_reg;
    assign hang         = hang_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int LIMIT = 8;
    localparam int MAXO  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_d, issue_long_d, use_rs1_d, use_rs2_d;
    logic [4:0] rd_d, rs1_d, rs2_d, wb_rd, rs1_e, rs2_e;
    logic       wb_valid, redirect_e;
    logic [1:0] stage_wr;
    logic [9:0] stage_rd;
    logic [2:0] fwd_rs1_e, fwd_rs2_e;
    logic       stall_f, stall_d, flush_d, flush_e, busy, err_spurious, hang;
    logic [2:0] outstanding;

    int errors = 0;
    int checks = 0;

    // Reference state: set of pending registers plus sticky flags.
    bit pend [32];
    bit m_err, m_hang;
    int m_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREGS(32), .RW(5), .NSTAGES(2), .MAX_OUT(MAXO), .STALL_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_d(issue_d), .issue_long_d(issue_long_d), .rd_d(rd_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .stage_wr(stage_wr), .stage_rd(stage_rd),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .redirect_e(redirect_e),
        .fwd_rs1_e(fwd_rs1_e), .fwd_rs2_e(fwd_rs2_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .outstanding(outstanding), .busy(busy),
        .err_spurious(err_spurious), .hang(hang)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pend_count();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(pend[r]);
        return n;
    endfunction

    // Youngest matching stage, else the register file.
    function automatic logic [2:0] ref_fwd(input logic [4:0] rs);
        logic [4:0] srd;
        if (rs == 5'd0) return 3'b001;
        for (int k = 0; k < 2; k++) begin
            srd = stage_rd[k*5 +: 5];
            if (stage_wr[k] && srd == rs) return 3'(1 << (k + 1));
        end
        return 3'b001;
    endfunction

    function automatic bit ref_stall();
        bit raw, waw, full;
        raw  = issue_d && ((use_rs1_d && pend[rs1_d]) || (use_rs2_d && pend[rs2_d]));
        waw  = issue_d && issue_long_d && pend[rd_d];
        full = issue_d && issue_long_d && (pend_count() == MAXO);
        return (raw || waw || full) && !redirect_e;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) pend[r] = 1'b0;
        m_err  = 1'b0;
        m_hang = 1'b0;
        m_cnt  = 0;
    endtask

    // One clock cycle: check combinational outputs mid-cycle, advance the
    // model on the edge, then check registered outputs just after it.
    task automatic step(input string tag);
        bit st, acc;
        @(negedge clk);
        st = ref_stall();
        chk({tag, ":fwd1"},    32'(fwd_rs1_e), 32'(ref_fwd(rs1_e)));
        chk({tag, ":fwd2"},    32'(fwd_rs2_e), 32'(ref_fwd(rs2_e)));
        chk({tag, ":stall_d"}, 32'(stall_d),   32'(st));
        chk({tag, ":stall_f"}, 32'(stall_f),   32'(st));
        chk({tag, ":flush_d"}, 32'(flush_d),   32'(redirect_e));
        chk({tag, ":flush_e"}, 32'(flush_e),   32'(st || redirect_e));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            acc = issue_d && issue_long_d && (rd_d != 5'd0) && !st && !redirect_e;
            if (wb_valid) begin
                if (pend[wb_rd]) pend[wb_rd] = 1'b0;
                else             m_err = 1'b1;
            end
            if (acc) pend[rd_d] = 1'b1;
            m_cnt = st ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
            if (m_cnt == LIMIT) m_hang = 1'b1;
        end
        #1;
        chk({tag, ":outstanding"}, 32'(outstanding),  32'(pend_count()));
        chk({tag, ":busy"},        32'(busy),         32'(pend_count() != 0));
        chk({tag, ":err"},         32'(err_spurious), 32'(m_err));
        chk({tag, ":hang"},        32'(hang),         32'(m_hang));
        $display("%0t %s rst_n=%0b iss=%0b lng=%0b rd=%0d rs1=%0d wb=%0b/%0d redir=%0b stall=%0b out=%0d err=%0b hang=%0b",
                 $time, tag, rst_n, issue_d, issue_long_d, rd_d, rs1_d, wb_valid, wb_rd,
                 redirect_e, st, outstanding, err_spurious, hang);
    endtask

    initial begin
        int q[$];
        rst_n = 1'b0; issue_d = 0; issue_long_d = 0; use_rs1_d = 0; use_rs2_d = 0;
        rd_d = 0; rs1_d = 0; rs2_d = 0; wb_valid = 0; wb_rd = 0;
        stage_wr = 0; stage_rd = 0; rs1_e = 0; rs2_e = 0; redirect_e = 0;

        // Reset state
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        chk("rst:outstanding", 32'(outstanding), 0);
        chk("rst:busy",        32'(busy), 0);
        chk("rst:err",         32'(err_spurious), 0);
        chk("rst:hang",        32'(hang), 0);
        chk("rst:fwd1",        32'(fwd_rs1_e), 1);
        chk("rst:flush_e",     32'(flush_e), 0);
        rst_n = 1'b1;

        // T1 bypass priority
        stage_wr = 2'b11; stage_rd = {5'd5, 5'd5}; rs1_e = 5'd5; #1;
        chk("t1:youngest", 32'(fwd_rs1_e), 32'b010);
        rs1_e = 5'd0; #1;
        chk("t1:x0", 32'(fwd_rs1_e), 32'b001);
        stage_wr = 2'b10; rs2_e = 5'd5; #1;
        chk("t1:older", 32'(fwd_rs2_e), 32'b100);
        step("t1");
        stage_wr = 0; rs2_e = 0;

        // T2 long RAW
        issue_d = 1; issue_long_d = 1; rd_d = 7;
        step("t2_issue");
        issue_long_d = 0; rd_d = 0; use_rs1_d = 1; rs1_d = 7; #1;
        chk("t2:raw_stall", 32'(stall_d), 1);
        chk("t2:raw_flush", 32'(flush_e), 1);
        step("t2_raw");
        wb_valid = 1; wb_rd = 7; #1;
        chk("t2:wb_same_cycle", 32'(stall_d), 1);
        step("t2_wb");
        wb_valid = 0; #1;
        chk("t2:released", 32'(stall_d), 0);
        chk("t2:out0", 32'(outstanding), 0);
        step("t2_go");

        // T3 full
        use_rs1_d = 0; issue_long_d = 1;
        for (int i = 1; i <= 4; i++) begin
            rd_d = 5'(i);
            step("t3_issue");
        end
        chk("t3:out4", 32'(outstanding), 4);
        rd_d = 5; #1;
        chk("t3:full_stall", 32'(stall_d), 1);
        step("t3_full");
        wb_valid = 1; wb_rd = 2;
        step("t3_wb");
        wb_valid = 0; #1;
        chk("t3:accept", 32'(stall_d), 0);
        step("t3_accept");
        chk("t3:out_still4", 32'(outstanding), 4);

        // T4 simultaneous accept/complete; rd=0 issue
        issue_d = 0; wb_valid = 1; wb_rd = 4;
        step("t4_free");
        issue_d = 1; issue_long_d = 1; rd_d = 9; wb_rd = 3;
        step("t4_both");
        chk("t4:out_same", 32'(outstanding), 3);
        wb_valid = 0; issue_long_d = 0; use_rs1_d = 1; rs1_d = 9; #1;
        chk("t4:x9_pending", 32'(stall_d), 1);
        step("t4_probe");
        issue_long_d = 1; use_rs1_d = 0; rd_d = 0;
        step("t4_x0");
        chk("t4:x0_nocount", 32'(outstanding), 3);

        // T5 redirect overrides stall; spurious completion
        issue_long_d = 0; use_rs1_d = 1; rs1_d = 1; redirect_e = 1; #1;
        chk("t5:no_stall", 32'(stall_d), 0);
        chk("t5:flush_d",  32'(flush_d), 1);
        chk("t5:flush_e",  32'(flush_e), 1);
        issue_long_d = 1; rd_d = 10;
        step("t5_redirect");
        chk("t5:no_accept", 32'(outstanding), 3);
        redirect_e = 0; issue_d = 0; wb_valid = 1; wb_rd = 12;
        step("t5_spur");
        chk("t5:err", 32'(err_spurious), 1);
        wb_valid = 0;

        // T6 watchdog, then reset mid-run
        issue_d = 1; issue_long_d = 0; use_rs1_d = 1; rs1_d = 1;
        repeat (LIMIT - 1) step("t6_stall");
        chk("t6:not_yet", 32'(hang), 0);
        step("t6_stall");
        chk("t6:hang", 32'(hang), 1);
        rst_n = 0;
        step("t6_reset");
        chk("t6:hang_clr", 32'(hang), 0);
        chk("t6:out_clr",  32'(outstanding), 0);
        rst_n = 1; issue_d = 0; wb_valid = 1; wb_rd = 5;
        step("t6_late_wb");
        chk("t6:late_err", 32'(err_spurious), 1);
        wb_valid = 0;
        rst_n = 0;
        step("rnd_reset");
        rst_n = 1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            issue_d      = ($urandom_range(0, 3) != 0);
            issue_long_d = $urandom_range(0, 1) != 0;
            rd_d         = 5'($urandom_range(0, 15));
            rs1_d        = 5'($urandom_range(0, 15));
            rs2_d        = 5'($urandom_range(0, 15));
            use_rs1_d    = $urandom_range(0, 1) != 0;
            use_rs2_d    = $urandom_range(0, 2) == 0;
            stage_wr     = 2'($urandom_range(0, 3));
            stage_rd     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rs1_e        = 5'($urandom_range(0, 7));
            rs2_e        = 5'($urandom_range(0, 7));
            redirect_e   = ($urandom_range(0, 7) == 0);
            wb_valid     = ($urandom_range(0, 2) == 0);
            q.delete();
            for (int r = 1; r < 32; r++) if (pend[r]) q.push_back(r);
            if (q.size() != 0 && $urandom_range(0, 9) != 0)
                wb_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                wb_rd = 5'($urandom_range(0, 15));
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
